demux4_dispatcher: RTL and testbench

Clocked controller that sequences a 1-to-4 demultiplexer datapath. It accepts data words from one upstream source using a valid/ready handshake. It stores each word in a single holding register and presents it to exactly one of four downstream channels. The channel is chosen either by an explicit select (fixed mode) or by a round-robin pointer that skips disabled channels. It sits between a single producer and four consumer ports, replacing free-running select inputs with a handshake-safe scheduler.

---
 rtl/demux4_dispatcher.sv | 119 +++++++++++
 tb/tb_demux4_dispatcher.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/demux4_dispatcher.sv
// Handshake-safe 1-to-4 dispatcher: one holding register, fixed or round-robin
// channel choice made at acceptance time, drained by the granted channel only.
module demux4_dispatcher #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic [1:0]    sel,
  input  logic [3:0]    en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [W-1:0]  out_data,
  output logic [1:0]    grant,
  output logic          full,
  output logic [CW-1:0] sent_cnt
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never retracts and its data stays stable until that transfer.
  typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    ptr_q, ptr_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       held;
  logic       out_fire;
  logic       accept;
  logic [1:0] eff_ptr;
  logic [1:0] scan_idx;
  logic [1:0] rr_tgt;
  logic [1:0] target;
  logic       target_valid;

  assign held     = (state_q == S_HOLD);
  assign out_fire = held & out_ready[grant_q];
  assign in_ready = rst_n & target_valid & (~held | out_fire);
  assign accept   = in_valid & in_ready;

  // A same-cycle accept must already see the pointer past the channel being
  // served, so the scan starts from grant+1 when a round-robin word drains.
  always_comb begin
    eff_ptr  = (out_fire && rr_q) ? grant_q + 2'd1 : ptr_q;
    rr_tgt   = eff_ptr;
    scan_idx = eff_ptr;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = eff_ptr + 2'(k);
      if (en[scan_idx]) rr_tgt = scan_idx;
    end
    if (mode) begin
      target       = rr_tgt;
      target_valid = |en;
    end else begin
      target       = sel;
      target_valid = en[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_HOLD;
      S_HOLD:  if (out_fire && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (out_fire) begin
      cnt_d = cnt_q + CW'(1);
      if (rr_q) ptr_d = grant_q + 2'd1;
    end
    if (accept) begin
      data_d  = in_data;
      grant_d = target;
      rr_d    = mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      grant_q <= 2'd0;
      ptr_q   <= 2'd0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    full      = held;
    out_valid = held ? (4'b0001 << grant_q) : 4'b0000;
    out_data  = data_q;
    grant     = grant_q;
    sent_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_demux4_dispatcher.sv
// Directed bench for demux4_dispatcher: a vector table for fixed/round-robin
// flows plus hand sequences for reset mid-hold, backpressure and counter wrap.
module tb_demux4_dispatcher;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic [1:0]    sel;
  logic [3:0]    en;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    grant;
  logic          full;
  logic [CW-1:0] sent_cnt;

  int n_checks = 0;
  int n_errors = 0;

  demux4_dispatcher #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .grant(grant), .full(full), .sent_cnt(sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          rst_n;
    logic          mode;
    logic [1:0]    sel;
    logic [3:0]    en;
    logic          iv;
    logic [W-1:0]  din;
    logic [3:0]    ordy;
    logic          exp_ir;
    logic [3:0]    exp_ov;
    logic [W-1:0]  exp_data;
    logic [1:0]    exp_gnt;
    logic          exp_full;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] ov, input logic [W-1:0] d,
                           input logic [1:0] g, input logic f, input logic [CW-1:0] c);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_data"},  32'(out_data),  32'(d));
    chk({tag, ".grant"},     32'(grant),     32'(g));
    chk({tag, ".full"},      32'(full),      32'(f));
    chk({tag, ".sent_cnt"},  32'(sent_cnt),  32'(c));
  endtask

  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] e,
                       input logic iv, input logic [W-1:0] d, input logic [3:0] r);
    mode = m; sel = s; en = e; in_valid = iv; in_data = d; out_ready = r;
  endtask

  initial begin
    // rst,mode,sel,en,iv,din,ordy | in_ready,out_valid,data,grant,full,cnt
    tbl[0]  = '{1'b1, 1'b0, 2'd1, 4'hF, 1'b1, 8'h11, 4'hF, 1'b1, 4'h0, 8'h00, 2'd0, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 2'd1, 4'hF, 1'b1, 8'h22, 4'hF, 1'b1, 4'h2, 8'h11, 2'd1, 1'b1, 4'd0};
    tbl[2]  = '{1'b1, 1'b0, 2'd1, 4'hF, 1'b0, 8'h00, 4'hF, 1'b1, 4'h2, 8'h22, 2'd1, 1'b1, 4'd1};
    tbl[3]  = '{1'b0, 1'b0, 2'd1, 4'hF, 1'b0, 8'h00, 4'hF, 1'b0, 4'h0, 8'h22, 2'd1, 1'b0, 4'd2};
    tbl[4]  = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 8'h30, 4'hF, 1'b1, 4'h0, 8'h00, 2'd0, 1'b0, 4'd0};
    tbl[5]  = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 8'h31, 4'hF, 1'b1, 4'h1, 8'h30, 2'd0, 1'b1, 4'd0};
    tbl[6]  = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 8'h32, 4'hF, 1'b1, 4'h2, 8'h31, 2'd1, 1'b1, 4'd1};
    tbl[7]  = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 8'h33, 4'hF, 1'b1, 4'h4, 8'h32, 2'd2, 1'b1, 4'd2};
    tbl[8]  = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 8'h34, 4'hF, 1'b1, 4'h8, 8'h33, 2'd3, 1'b1, 4'd3};
    tbl[9]  = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 8'h00, 4'hF, 1'b1, 4'h1, 8'h34, 2'd0, 1'b1, 4'd4};
    tbl[10] = '{1'b1, 1'b1, 2'd0, 4'hA, 1'b1, 8'h40, 4'hF, 1'b1, 4'h0, 8'h34, 2'd0, 1'b0, 4'd5};
    tbl[11] = '{1'b1, 1'b1, 2'd0, 4'hA, 1'b1, 8'h41, 4'hF, 1'b1, 4'h2, 8'h40, 2'd1, 1'b1, 4'd5};
    tbl[12] = '{1'b1, 1'b1, 2'd0, 4'hA, 1'b1, 8'h42, 4'hF, 1'b1, 4'h8, 8'h41, 2'd3, 1'b1, 4'd6};
    tbl[13] = '{1'b1, 1'b1, 2'd0, 4'hA, 1'b1, 8'h43, 4'hF, 1'b1, 4'h2, 8'h42, 2'd1, 1'b1, 4'd7};
    tbl[14] = '{1'b1, 1'b1, 2'd0, 4'h0, 1'b1, 8'h44, 4'h0, 1'b0, 4'h8, 8'h43, 2'd3, 1'b1, 4'd8};
    tbl[15] = '{1'b1, 1'b1, 2'd0, 4'h0, 1'b1, 8'h44, 4'h8, 1'b0, 4'h8, 8'h43, 2'd3, 1'b1, 4'd8};
    tbl[16] = '{1'b1, 1'b1, 2'd0, 4'h0, 1'b1, 8'h44, 4'hF, 1'b0, 4'h0, 8'h43, 2'd3, 1'b0, 4'd9};

    // Reset: in_ready must stay low even with a valid, enabled request.
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'hF, 1'b1, 8'h5A, 4'hF);
    repeat (3) @(posedge clk);
    #2;
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    chk_state("reset", 4'h0, 8'h00, 2'd0, 1'b0, 4'd0);

    // Table: fixed flow, reset, RR rotation, RR skip, en=0 drain.
    for (int i = 0; i < 17; i++) begin
      cyc();
      rst_n = tbl[i].rst_n;
      drive(tbl[i].mode, tbl[i].sel, tbl[i].en, tbl[i].iv, tbl[i].din, tbl[i].ordy);
      #1;
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ir));
      chk_state($sformatf("vec%0d", i), tbl[i].exp_ov, tbl[i].exp_data, tbl[i].exp_gnt,
                tbl[i].exp_full, tbl[i].exp_cnt);
    end

    // Reset asserted while a word is held on channel 2.
    cyc();
    drive(1'b0, 2'd2, 4'hF, 1'b1, 8'hA5, 4'h0);
    cyc();
    in_valid = 1'b0;
    #1;
    chk_state("midhold", 4'h4, 8'hA5, 2'd2, 1'b1, 4'd9);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("midhold_rst.in_ready", 32'(in_ready), 32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk_state("after_rst", 4'h0, 8'h00, 2'd0, 1'b0, 4'd0);

    // Backpressure on fixed channel 3, then release with no bubble.
    drive(1'b0, 2'd3, 4'hF, 1'b1, 8'hB0, 4'h0);
    cyc();
    in_data = 8'hB1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp%0d.out_valid", i), 32'(out_valid), 32'h8);
      chk($sformatf("bp%0d.out_data", i), 32'(out_data), 32'hB0);
      chk($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'd0);
      cyc();
    end
    out_ready = 4'h8;
    #1;
    chk("bp_release.in_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    #1;
    chk_state("bp_next", 4'h8, 8'hB1, 2'd3, 1'b1, 4'd1);
    cyc();
    #1;
    chk_state("bp_drain", 4'h0, 8'hB1, 2'd3, 1'b0, 4'd2);

    // Counter wrap: 17 transfers through a 4-bit counter.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 4'hF, 1'b1, 8'h00, 4'hF);
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("wrap16.sent_cnt", 32'(sent_cnt), 32'd0);
    chk("wrap16.out_data", 32'(out_data), 32'd16);
    cyc();
    #1;
    chk("wrap17.sent_cnt", 32'(sent_cnt), 32'd1);
    chk("wrap17.full", 32'(full), 32'd0);

    // Changing sel/mode/en while holding must not move the grant.
    drive(1'b0, 2'd1, 4'hF, 1'b1, 8'hC3, 4'h0);
    cyc();
    in_valid = 1'b0;
    sel = 2'd2;
    mode = 1'b1;
    en = 4'h4;
    cyc();
    cyc();
    #1;
    chk_state("hold_sticky", 4'h2, 8'hC3, 2'd1, 1'b1, 4'd1);
    out_ready = 4'hF;
    #1;
    chk("hold_sticky.in_ready", 32'(in_ready), 32'd1);
    cyc();
    #1;
    chk_state("hold_drain", 4'h0, 8'hC3, 2'd1, 1'b0, 4'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
